// File: rtl/darkflash_axi_bridge.sv
// darkflash_axi_bridge: read-only device_bus to AXI4-Lite (AR/R) bridge; define DARKFLASH_PREFETCH_EN for a one-entry next-word prefetch buffer.
// Latency: RACK in the 3rd cycle after a sampled read at best (1 on a prefetch hit); WACK 1 cycle after a sampled write.
// Backpressure: ARVALID held until ARREADY, RREADY held until RVALID; bus requests stall unacknowledged until the bridge returns to IDLE.
module darkflash_axi_bridge #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0013
) (
  input  logic              XCLK,
  input  logic              XRES,
  input  logic              BUS_EN,
  input  logic              BUS_RE,
  input  logic              BUS_WE,
  input  logic [31:0]       BUS_ADDR,
  output logic [31:0]       BUS_DATA,
  output logic              BUS_RACK,
  output logic              BUS_WACK,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              ERR
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_R     = 3'd2,
    S_ACK   = 3'd3,
    S_WACK  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_araddr, w_araddr_nxt;
  logic              r_arvalid, w_arvalid_nxt;
  logic              r_rready, w_rready_nxt;
  logic [31:0]       r_data, w_data_nxt;
  logic              r_rack, w_rack_nxt;
  logic              r_wack, w_wack_nxt;
  logic              r_err, w_err_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic [ADDR_W-1:0] w_req_addr;
  logic              w_to;
  logic              w_to_fire;
  logic              w_unused;

`ifdef DARKFLASH_PREFETCH_EN
  logic              r_pf_busy, w_pf_busy_nxt;
  logic              r_ack_pf, w_ack_pf_nxt;
  logic              r_pf_vld, w_pf_vld_nxt;
  logic [ADDR_W-1:0] r_pf_tag, w_pf_tag_nxt;
  logic [31:0]       r_pf_data, w_pf_data_nxt;
`endif

  assign w_req_addr = {BUS_ADDR[ADDR_W-1:2], 2'b00};
  assign w_to       = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_unused   = ^BUS_ADDR;

  always_comb begin
    w_state_nxt   = r_state;
    w_araddr_nxt  = r_araddr;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_data_nxt    = r_data;
    w_rack_nxt    = 1'b0;
    w_wack_nxt    = 1'b0;
    w_err_nxt     = r_err;
    w_cnt_nxt     = r_cnt;
    w_to_fire     = 1'b0;
`ifdef DARKFLASH_PREFETCH_EN
    w_pf_busy_nxt = r_pf_busy;
    w_ack_pf_nxt  = r_ack_pf;
    w_pf_vld_nxt  = r_pf_vld;
    w_pf_tag_nxt  = r_pf_tag;
    w_pf_data_nxt = r_pf_data;
`endif

    case (r_state)
      S_IDLE: begin
        if (BUS_EN && BUS_RE) begin
`ifdef DARKFLASH_PREFETCH_EN
          if (r_pf_vld && (r_pf_tag == w_req_addr)) begin
            w_rack_nxt   = 1'b1;
            w_data_nxt   = r_pf_data;
            w_araddr_nxt = r_pf_tag;
            w_ack_pf_nxt = 1'b1;
            w_state_nxt  = S_ACK;
          end else
`endif
          begin
            w_araddr_nxt  = w_req_addr;
            w_arvalid_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_AR;
          end
        end else if (BUS_EN && BUS_WE) begin
          w_wack_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_WACK;
        end
      end

      S_AR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_R;
        end
        w_to_fire = w_to;
      end

      S_R: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (RVALID) begin
          w_rready_nxt = 1'b0;
`ifdef DARKFLASH_PREFETCH_EN
          if (r_pf_busy) begin
            w_pf_busy_nxt = 1'b0;
            w_pf_vld_nxt  = (RRESP == 2'b00);
            w_pf_tag_nxt  = r_araddr;
            w_pf_data_nxt = RDATA;
            w_state_nxt   = S_IDLE;
          end else
`endif
          begin
            w_rack_nxt  = 1'b1;
            w_state_nxt = S_ACK;
            if (RRESP == 2'b00) begin
              w_data_nxt = RDATA;
            end else begin
              w_data_nxt = ERR_DATA;
              w_err_nxt  = 1'b1;
            end
`ifdef DARKFLASH_PREFETCH_EN
            w_ack_pf_nxt = (RRESP == 2'b00);
            if (RRESP != 2'b00) w_pf_vld_nxt = 1'b0;
`endif
          end
        end else begin
          w_to_fire = w_to;
        end
      end

      S_ACK: begin
        w_state_nxt = S_IDLE;
`ifdef DARKFLASH_PREFETCH_EN
        // Speculatively fetch the next word while the core consumes this one.
        if (r_ack_pf) begin
          w_araddr_nxt  = r_araddr + ADDR_W'(4);
          w_arvalid_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_pf_busy_nxt = 1'b1;
          w_pf_vld_nxt  = 1'b0;
          w_ack_pf_nxt  = 1'b0;
          w_state_nxt   = S_AR;
        end
`endif
      end

      S_WACK: begin
        w_state_nxt = S_IDLE;
      end

      S_DRAIN: begin
        if (r_arvalid && ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
        if (r_rready && RVALID) begin
          w_rready_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
`ifdef DARKFLASH_PREFETCH_EN
          w_pf_busy_nxt = 1'b0;
`endif
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A stalled slave still owes us a handshake, so the AXI side is finished off in DRAIN.
    if (w_to_fire) begin
      w_state_nxt = S_DRAIN;
`ifdef DARKFLASH_PREFETCH_EN
      w_pf_vld_nxt = 1'b0;
      if (!r_pf_busy) begin
        w_rack_nxt = 1'b1;
        w_data_nxt = ERR_DATA;
        w_err_nxt  = 1'b1;
      end
`else
      w_rack_nxt = 1'b1;
      w_data_nxt = ERR_DATA;
      w_err_nxt  = 1'b1;
`endif
    end
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      r_state   <= S_IDLE;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_data    <= '0;
      r_rack    <= 1'b0;
      r_wack    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
`ifdef DARKFLASH_PREFETCH_EN
      r_pf_busy <= 1'b0;
      r_ack_pf  <= 1'b0;
      r_pf_vld  <= 1'b0;
      r_pf_tag  <= '0;
      r_pf_data <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_araddr  <= w_araddr_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_data    <= w_data_nxt;
      r_rack    <= w_rack_nxt;
      r_wack    <= w_wack_nxt;
      r_err     <= w_err_nxt;
      r_cnt     <= w_cnt_nxt;
`ifdef DARKFLASH_PREFETCH_EN
      r_pf_busy <= w_pf_busy_nxt;
      r_ack_pf  <= w_ack_pf_nxt;
      r_pf_vld  <= w_pf_vld_nxt;
      r_pf_tag  <= w_pf_tag_nxt;
      r_pf_data <= w_pf_data_nxt;
`endif
    end
  end

  assign BUS_DATA = r_data;
  assign BUS_RACK = r_rack;
  assign BUS_WACK = r_wack;
  assign ARADDR   = r_araddr;
  assign ARVALID  = r_arvalid;
  assign RREADY   = r_rready;
  assign ERR      = r_err;

endmodule
